// File: rtl/fifo_sync_ctrl.sv
// Synchronous FIFO controller driving an external registered-read dual-port memory.
// Hides the one-cycle read latency and the read-during-write hazard behind valid/ready streams.
package fifo_pkg;
    localparam int ADDR_WIDTH = 2;
    localparam int DATA_WIDTH = 8;
endpackage

module fifo_sync_ctrl #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);
    localparam int                DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_COUNT   = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] wr_ptr_dly;
    logic [ADDR_WIDTH:0] rd_ptr_nxt;
    logic                full;
    logic                push;
    logic                pop;

    // wr_ptr_dly lags wr_ptr by one edge so a freshly written slot is never read in its write cycle.
    always_comb begin
        count       = wr_ptr - rd_ptr;
        full        = (count == FULL_COUNT);
        in_ready    = !full;
        empty       = (count == '0);
        almost_full = (count >= AF_COUNT);
        out_valid   = (rd_ptr != wr_ptr_dly);
        push        = in_valid && in_ready && !flush;
        pop         = out_valid && out_ready && !flush;
        rd_ptr_nxt  = flush ? '0 : (rd_ptr + {{ADDR_WIDTH{1'b0}}, pop});
    end

    always_comb begin
        mem_wr_en   = push;
        mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
        mem_wr_data = in_data;
        mem_rd_addr = rd_ptr_nxt[ADDR_WIDTH-1:0];
        out_data    = mem_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_ptr_dly <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_ptr_dly <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr     <= rd_ptr_nxt;
            wr_ptr_dly <= wr_ptr;
        end
    end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed bench for fifo_sync_ctrl with a registered-read memory model and a queue-based
// reference model checked every cycle, plus literal expectations for the key scenarios.
module tb_fifo_sync_ctrl;
    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW:0]   count;
    logic          empty;
    logic          almost_full;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] mem [DEPTH];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Registered-read memory: a read of the slot being written returns the old contents.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_rd_addr];
    end

    fifo_sync_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_LEVEL(AF)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .empty(empty), .almost_full(almost_full),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        int            edge_no;
    } entry_t;

    entry_t model_q[$];
    int     edge_cnt = 0;
    int     wr_total = 0;

    // An entry pushed at edge n is presented once at least one further edge has passed.
    function automatic bit m_valid();
        return (model_q.size() > 0) && (model_q[0].edge_no + 1 <= edge_cnt);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [DW-1:0] d,
                                 input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            edge_cnt = 0;
            wr_total = 0;
        end else begin
            bit do_pop;
            bit do_push;
            entry_t e;
            do_pop  = m_valid() && out_ready;
            do_push = in_valid && (model_q.size() < DEPTH);
            if (flush) begin
                model_q.delete();
                wr_total = 0;
            end else begin
                if (do_pop) void'(model_q.pop_front());
                if (do_push) begin
                    e.data    = in_data;
                    e.edge_no = edge_cnt + 1;
                    model_q.push_back(e);
                    wr_total++;
                end
            end
            edge_cnt++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int n;
            bit ev;
            bit ew;
            n  = model_q.size();
            ev = m_valid();
            ew = in_valid && (n < DEPTH) && !flush;
            checkOutput("m_count", 32'(count), 32'(n));
            checkOutput("m_empty", 32'(empty), 32'(n == 0));
            checkOutput("m_almost_full", 32'(almost_full), 32'(n >= AF));
            checkOutput("m_in_ready", 32'(in_ready), 32'(n < DEPTH));
            checkOutput("m_out_valid", 32'(out_valid), 32'(ev));
            checkOutput("m_mem_wr_en", 32'(mem_wr_en), 32'(ew));
            if (ev) checkOutput("m_out_data", 32'(out_data), 32'(model_q[0].data));
            if (ew) begin
                checkOutput("m_wr_addr", 32'(mem_wr_addr), 32'(wr_total % DEPTH));
                checkOutput("m_wr_data", 32'(mem_wr_data), 32'(in_data));
            end
        end
    end

    initial begin
        logic [DW-1:0] got[$];
        logic [AW-1:0] wa[$];
        int sent;
        int cyc;

        #2 rst_n = 1'b0;
        #10;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
        checkOutput("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Single push and hold
        applyStimulus(1, 8'hA5, 0, 0);
        @(negedge clk);
        checkOutput("sp_wr_en", 32'(mem_wr_en), 32'd1);
        checkOutput("sp_wr_addr", 32'(mem_wr_addr), 32'd0);
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("sp_c1_count", 32'(count), 32'd1);
        checkOutput("sp_c1_empty", 32'(empty), 32'd0);
        checkOutput("sp_c1_valid", 32'(out_valid), 32'd0);
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("sp_c2_valid", 32'(out_valid), 32'd1);
        checkOutput("sp_c2_data", 32'(out_data), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 8'h00, 0, 0);
            @(negedge clk);
            checkOutput("sp_hold_data", 32'(out_data), 32'hA5);
        end
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("sp_drained_empty", 32'(empty), 32'd1);

        // Fill and drain
        for (int i = 1; i <= 4; i++) applyStimulus(1, DW'(i), 0, 0);
        @(negedge clk);
        checkOutput("fd_count3", 32'(count), 32'd3);
        checkOutput("fd_af3", 32'(almost_full), 32'd1);
        applyStimulus(1, 8'h05, 0, 0);
        @(negedge clk);
        checkOutput("fd_count4", 32'(count), 32'd4);
        checkOutput("fd_in_ready", 32'(in_ready), 32'd0);
        checkOutput("fd_no_wr", 32'(mem_wr_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 8'h00, 1, 0);
            @(negedge clk);
            checkOutput("fd_pop_valid", 32'(out_valid), 32'd1);
            checkOutput("fd_pop_data", 32'(out_data), 32'(i + 1));
            checkOutput("fd_pop_count", 32'(count), 32'(4 - i));
        end
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("fd_end_empty", 32'(empty), 32'd1);
        checkOutput("fd_end_valid", 32'(out_valid), 32'd0);

        // Wrap with random back-pressure, starting from cleared pointers
        applyStimulus(0, 8'h00, 0, 1);
        sent = 0;
        cyc  = 0;
        while (got.size() < 12 && cyc < 200) begin
            applyStimulus(sent < 12, DW'(8'h10 + sent), 1'($urandom_range(0, 1)), 0);
            @(negedge clk);
            if (mem_wr_en) wa.push_back(mem_wr_addr);
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) got.push_back(out_data);
            cyc++;
        end
        checkOutput("wrap_received", 32'(got.size()), 32'd12);
        checkOutput("wrap_writes", 32'(wa.size()), 32'd12);
        foreach (got[i]) checkOutput("wrap_order", 32'(got[i]), 32'(8'h10 + i));
        foreach (wa[i]) checkOutput("wrap_wr_addr", 32'(wa[i]), 32'(i % 4));
        applyStimulus(0, 8'h00, 0, 0);

        // Simultaneous push and pop at count 2, then at full
        applyStimulus(1, 8'h30, 0, 0);
        applyStimulus(1, 8'h31, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, DW'(8'h32 + i), 1, 0);
            @(negedge clk);
            checkOutput("sim_count", 32'(count), 32'd2);
            checkOutput("sim_data", 32'(out_data), 32'(8'h30 + i));
        end
        applyStimulus(1, 8'h3C, 0, 0);
        applyStimulus(1, 8'h3D, 0, 0);
        applyStimulus(1, 8'hEE, 1, 0);
        @(negedge clk);
        checkOutput("full_both_count", 32'(count), 32'd4);
        checkOutput("full_both_ready", 32'(in_ready), 32'd0);
        checkOutput("full_both_data", 32'(out_data), 32'h3A);
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("full_after_count", 32'(count), 32'd3);
        checkOutput("full_after_data", 32'(out_data), 32'h3B);

        // Flush with concurrent push and pop
        applyStimulus(1, 8'h99, 1, 1);
        @(negedge clk);
        checkOutput("fl_wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("fl_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("fl_count", 32'(count), 32'd0);
        checkOutput("fl_empty", 32'(empty), 32'd1);
        checkOutput("fl_valid", 32'(out_valid), 32'd0);
        applyStimulus(1, 8'h77, 0, 0);
        @(negedge clk);
        checkOutput("fl_push_addr", 32'(mem_wr_addr), 32'd0);
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("fl_c1_valid", 32'(out_valid), 32'd0);
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("fl_c2_valid", 32'(out_valid), 32'd1);
        checkOutput("fl_c2_data", 32'(out_data), 32'h77);

        // Asynchronous reset mid-stream
        applyStimulus(1, 8'h56, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("ar_pre_count", 32'(count), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("ar_count", 32'(count), 32'd0);
        checkOutput("ar_valid", 32'(out_valid), 32'd0);
        checkOutput("ar_empty", 32'(empty), 32'd1);
        checkOutput("ar_in_ready", 32'(in_ready), 32'd1);
        checkOutput("ar_almost_full", 32'(almost_full), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 8'h00, 0, 0);
            @(negedge clk);
            checkOutput("ar_idle_valid", 32'(out_valid), 32'd0);
        end
        applyStimulus(1, 8'h66, 0, 0);
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("ar_c1_valid", 32'(out_valid), 32'd0);
        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        checkOutput("ar_c2_valid", 32'(out_valid), 32'd1);
        checkOutput("ar_c2_data", 32'(out_data), 32'h66);

        applyStimulus(0, 8'h00, 0, 0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
- Single-clock controller that sequences one fifo_mem instance (both memory clocks tied to clk) as a synchronous FIFO with valid/ready handshakes on the push and pop sides.
- Owns the write and read pointers, the full/empty/count status and the memory port drive.
- Hides the one-cycle registered read latency of the memory, including the read-during-write hazard, so consumers see a clean valid/ready stream.

Parameters:
- ADDR_WIDTH, fifo_pkg::ADDR_WIDTH, memory address width; DEPTH = 1<<ADDR_WIDTH.
- DATA_WIDTH, fifo_pkg::DATA_WIDTH, payload width.
- AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.

Ports:
- clk  in  1  single clock; also drives the memory wr_clk and rd_clk.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all FIFO contents.
- in_valid  in  1  push request.
- in_ready  out  1  push accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  push payload.
- out_valid  out  1  out_data holds the head entry.
- out_ready  in  1  pop accepted when out_valid && out_ready.
- out_data  out  DATA_WIDTH  head payload.
- count  out  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- mem_wr_en  out  1  to memory wr_en.
- mem_wr_addr  out  ADDR_WIDTH  to memory wr_addr.
- mem_wr_data  out  DATA_WIDTH  to memory wr_data.
- mem_rd_addr  out  ADDR_WIDTH  to memory rd_addr.
- mem_rd_data  in  DATA_WIDTH  from memory rd_data (registered, 1-cycle latency).

Behaviour:
- State registers:
  - wr_ptr, rd_ptr: ADDR_WIDTH+1 bits each; the MSB is the wrap bit.
  - wr_ptr_dly: wr_ptr registered one cycle.
  - No other state.
- Reset (async, rst_n=0): all pointers 0.
  - Outputs: in_ready=1, out_valid=0, count=0, empty=1, almost_full=0 (AF_LEVEL>=1), mem_wr_en=0.
- Event definitions:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
- Status:
  - count = wr_ptr - rd_ptr (modular, ADDR_WIDTH+1 bits).
  - full when count == DEPTH.
  - in_ready = !full. It is independent of out_ready: no push into a full FIFO even if a pop occurs in the same cycle.
- Write path (all combinational):
  - mem_wr_en = push.
  - mem_wr_addr = wr_ptr[ADDR_WIDTH-1:0].
  - mem_wr_data = in_data.
  - wr_ptr increments on push.
- Read path:
  - rd_ptr_nxt = rd_ptr + pop.
  - mem_rd_addr = rd_ptr_nxt[ADDR_WIDTH-1:0] (combinational), so after each edge mem_rd_data = mem[rd_ptr].
  - out_data = mem_rd_data.
  - out_valid = (rd_ptr != wr_ptr_dly). An entry written at edge E becomes visible after edge E+1, which avoids reading a location in the same cycle it is written.
- Latency:
  - Push-to-out_valid on an empty FIFO is 2 cycles.
  - Back-to-back pops sustain 1 entry/cycle when data is present.
  - Simultaneous push and pop is allowed in any non-full state; count is unchanged.
- empty is derived from count, not from out_valid. In the cycle after a push into an empty FIFO, empty=0 while out_valid=0.
- Wrap: pointers roll over modulo 2*DEPTH. The address is the low ADDR_WIDTH bits; full vs empty is distinguished by the MSB.
- flush (sync, highest priority):
  - At the edge: wr_ptr=rd_ptr=wr_ptr_dly=0. Any push or pop in that cycle is discarded and does not count.
  - mem_wr_en is forced 0 while flush=1, and in_ready is still reported as !full.
  - out_valid=0 from the next cycle.
- Async reset mid-operation: immediate return to reset values. Memory contents are not cleared and are never exposed afterwards.
- out_data must be held stable while out_valid && !out_ready. This follows from mem_rd_addr being unchanged when pop=0.

Test Plan:
- Single push: ADDR_WIDTH=2; push 0xA5 at cycle 0 with out_ready=0 -> cycle 1: count=1, empty=0, out_valid=0; cycle 2: out_valid=1, out_data=0xA5; hold 5 cycles and data stays stable.
- Fill and drain: push 0x1,0x2,0x3,0x4 back-to-back -> in_ready=0 and count=4 after the 4th push, almost_full=1 at count=3. A 5th push attempt is not accepted. Pop 4 with out_ready=1 -> outputs 1,2,3,4 on consecutive cycles; then empty=1, out_valid=0.
- Wrap: repeat push/pop of 12 incrementing values with random out_ready -> order preserved across 3 pointer wraps; mem_wr_addr sequence 0,1,2,3,0,... .
- Simultaneous push/pop: at count=2, push and pop together for 10 cycles -> count stays 2, no lost or duplicated data. At count=4 with in_valid=1 and out_ready=1 -> only the pop occurs; count goes 4->3.
- Flush: count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, empty=1, out_valid=0, no mem_wr_en pulse. A subsequent push of 0x77 appears at out_data two cycles later.
- Reset mid-stream: deassert rst_n asynchronously with count=2 -> outputs at reset values immediately. After release, out_valid stays 0 until a new push plus 2 cycles.
